clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_ctrl_pkg.sv | 37 +++
 rtl/clock_set_ctrl_if.sv | 25 ++
 rtl/btn_debounce.sv | 40 ++++
 rtl/clock_set_ctrl.sv | 101 ++++++++++
 tb/tb_clock_set_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock-setting controller: FSM states,
// blink field codes and the default debounce length.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_F1 = 2'd1,
        SET_F2 = 2'd2,
        SET_F3 = 2'd3
    } state_t;

    localparam logic [1:0]  FLD_NONE = 2'b00;
    localparam logic [1:0]  FLD_HI   = 2'b01;
    localparam logic [1:0]  FLD_MID  = 2'b10;
    localparam logic [1:0]  FLD_LO   = 2'b11;

    localparam logic [19:0] DEBOUNCE_DEFAULT = 20'd1000000;

    function automatic state_t next_state(input state_t s);
        case (s)
            RUN:     return SET_F1;
            SET_F1:  return SET_F2;
            SET_F2:  return SET_F3;
            default: return RUN;
        endcase
    endfunction

    function automatic logic [1:0] field_code(input state_t s);
        case (s)
            SET_F1:  return FLD_HI;
            SET_F2:  return FLD_MID;
            SET_F3:  return FLD_LO;
            default: return FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, tick and control-output bundle between the panel (master) and
// the clock-setting controller (slave).
interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_sel;
    logic       btn_up;
    logic       btn_down;
    logic       tick_1hz;
    logic       smh_dmy;
    logic       dem_chinh;
    logic [1:0] blink_led;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       clr_sec;

    modport master (
        output btn_mode, btn_sel, btn_up, btn_down, tick_1hz,
        input  smh_dmy, dem_chinh, blink_led, inc_pulse, dec_pulse, clr_sec
    );

    modport slave (
        input  btn_mode, btn_sel, btn_up, btn_down, tick_1hz,
        output smh_dmy, dem_chinh, blink_led, inc_pulse, dec_pulse, clr_sec
    );
endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> debounce counter -> one-cycle pulse
// on each accepted press.
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = clock_ctrl_pkg::DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic [1:0]  sync;
    logic        stable;
    logic [19:0] cnt;

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= 2'b00;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
                // level held different for DEBOUNCE_CYCLES cycles: accept it
                stable <= sync[1];
                cnt    <= '0;
                pulse  <= sync[1];
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock/date set-mode controller: four debounced buttons drive field editing.
// Define CLOCK_SET_TIMEOUT_EN to leave set mode after TIMEOUT_S idle seconds.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int          TIMEOUT_S       = 30
) (
    input  logic         clk,
    input  logic         rst_n,
    clock_set_ctrl_if.slave bus
);

    logic ev_mode, ev_sel, ev_up, ev_down;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_mode), .pulse(ev_mode));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_sel), .pulse(ev_sel));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_up), .pulse(ev_up));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_down), .pulse(ev_down));

    state_t     state;
    logic       smh_q, dem_q, inc_q, dec_q, clr_q;
    logic [1:0] blink_q;
    logic       adjust;
    logic       timeout;

    // Simultaneous up and down cancel each other.
    assign adjust = (state != RUN) && (ev_up ^ ev_down);

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int             IW        = $clog2(TIMEOUT_S + 1);
    localparam logic [IW-1:0]  TIMEOUT_V = IW'(TIMEOUT_S);

    logic [IW-1:0] idle;
    logic          any_ev;

    assign any_ev  = ev_mode | ev_sel | ev_up | ev_down;
    assign timeout = (state != RUN) && (idle == TIMEOUT_V);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle <= '0;
        end else if (state == RUN || any_ev) begin
            idle <= '0;
        end else if (bus.tick_1hz && idle != TIMEOUT_V) begin
            idle <= idle + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            smh_q   <= 1'b0;
            blink_q <= FLD_NONE;
            dem_q   <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle, so each one lasts exactly
            // one clock and nothing holds a stale value.
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            clr_q <= 1'b0;
            if (ev_sel)
                smh_q <= ~smh_q;
            if (ev_mode) begin
                state   <= next_state(state);
                blink_q <= field_code(next_state(state));
                dem_q   <= (next_state(state) != RUN);
            end else if (adjust) begin
                // Editing seconds resets them rather than stepping them.
                if (state == SET_F3 && !smh_q) begin
                    clr_q <= 1'b1;
                end else begin
                    inc_q <= ev_up;
                    dec_q <= ev_down;
                end
            end else if (timeout) begin
                state   <= RUN;
                blink_q <= FLD_NONE;
                dem_q   <= 1'b0;
            end
        end
    end

    assign bus.smh_dmy   = smh_q;
    assign bus.dem_chinh = dem_q;
    assign bus.blink_led = blink_q;
    assign bus.inc_pulse = inc_q;
    assign bus.dec_pulse = dec_q;
    assign bus.clr_sec   = clr_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a small model pushes expected strobes,
// a negedge monitor collects observed strobes, and the two are compared.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

    typedef struct packed {
        logic       inc;
        logic       dec;
        logic       clr;
        logic [2:0] fld;
    } strobe_t;

    logic clk = 1'b0;
    logic rst_n;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(20'd4),
        .TIMEOUT_S      (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    strobe_t    exp_q[$];
    strobe_t    obs_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         blink_changes = 0;
    logic [1:0] last_blink = 2'b00;
    logic [1:0] fld = 2'b00;
    logic       smh = 1'b0;

    always @(negedge clk) begin
        if (bus.inc_pulse || bus.dec_pulse || bus.clr_sec)
            obs_q.push_back({bus.inc_pulse, bus.dec_pulse, bus.clr_sec,
                             bus.smh_dmy, bus.blink_led});
        if (bus.blink_led !== last_blink) begin
            blink_changes = blink_changes + 1;
            last_blink    = bus.blink_led;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag);
        strobe_t o, e;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_strobe"}, 32'(o), 32'(e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_view(input string tag);
        check({tag, "_blink"}, 32'(bus.blink_led), 32'(fld));
        check({tag, "_dem"},   32'(bus.dem_chinh), 32'(fld != 2'b00));
        check({tag, "_smh"},   32'(bus.smh_dmy),   32'(smh));
    endtask

    // Expected behaviour of one simultaneous button event {down,up,sel,mode}.
    task automatic model(input logic [3:0] m);
        strobe_t s;
        if (m[0]) begin
            fld = fld + 2'd1;
        end else if (fld != 2'b00 && (m[2] ^ m[3])) begin
            s     = '0;
            s.fld = {smh, fld};
            if (fld == 2'b11 && !smh) s.clr = 1'b1;
            else begin
                s.inc = m[2];
                s.dec = m[3];
            end
            exp_q.push_back(s);
        end
        if (m[1]) smh = ~smh;
    endtask

    task automatic drive(input logic [3:0] m);
        bus.btn_mode = m[0];
        bus.btn_sel  = m[1];
        bus.btn_up   = m[2];
        bus.btn_down = m[3];
    endtask

    task automatic press(input logic [3:0] m, input int len = 6);
        model(m);
        @(negedge clk);
        drive(m);
        repeat (len) @(negedge clk);
        drive(4'b0000);
        repeat (12) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.tick_1hz = 1'b1;
        @(negedge clk);
        bus.tick_1hz = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b0001);
        bus.tick_1hz = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state, with mode held throughout reset.
        check_view("reset");
        check("reset_strobes", 32'({bus.inc_pulse, bus.dec_pulse, bus.clr_sec}), 32'd0);
        blink_changes = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("no_event_after_release", 32'(bus.blink_led), 32'd0);
        repeat (9) @(negedge clk);
        drive(4'b0000);
        repeat (12) @(negedge clk);
        fld = 2'b01;
        check_view("held_mode");
        check("one_transition", 32'(blink_changes), 32'd1);

        // Short glitches on up are rejected.
        repeat (3) begin
            @(negedge clk);
            bus.btn_up = 1'b1;
            repeat (2) @(negedge clk);
            bus.btn_up = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_sb("glitch");

        press(4'b0001);
        check_view("f2");
        press(4'b0100);
        check_sb("f2_up");

        // Seconds field: clear instead of step, then date year field steps.
        press(4'b0001);
        check_view("f3");
        press(4'b0100);
        check_sb("f3_clr");
        press(4'b0010);
        check_view("f3_sel");
        press(4'b0100);
        press(4'b1000);
        check_sb("f3_date");

        press(4'b0001);
        check_view("run");
        press(4'b0100);
        press(4'b1100);
        check_sb("run_ignored");

        press(4'b0001);
        press(4'b1100);
        check_sb("f1_both");
        press(4'b0011);
        check_view("mode_sel");
        press(4'b0101);
        check_view("mode_up");
        check_sb("mode_up");

        press(4'b0001);
        check_view("back_run");
        for (int i = 0; i < 4; i++) begin
            press(4'b0001);
            check_view($sformatf("cycle%0d", i));
        end

        press(4'b0001);
`ifdef CLOCK_SET_TIMEOUT_EN
        tick();
        tick();
        press(4'b0100);
        tick();
        tick();
        check_view("restart");
        tick();
        fld = 2'b00;
        check_view("timeout");
        check_sb("timeout");
`else
        repeat (10) tick();
        check_view("no_timeout");
        check_sb("no_timeout");
`endif

        // Reset while editing aborts with no strobe.
        if (fld == 2'b00) press(4'b0001);
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (12) @(negedge clk);
        fld = 2'b00;
        smh = 1'b0;
        check_view("reset_abort");
        check_sb("reset_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
